// File: rtl/empty_ptr_storage.sv
// empty_ptr_storage: circular FIFO of free table pointers, self-filled with 0..N-1 after reset
package hash_table;
   localparam int TABLE_ADDR_WIDTH = 8;
endpackage

module empty_ptr_storage #(
   parameter int A_WIDTH = hash_table::TABLE_ADDR_WIDTH
) (
   input  logic               clk,
   input  logic               srst,
   input  logic [A_WIDTH-1:0] add_empty_ptr,
   input  logic               add_empty_ptr_en,
   input  logic               next_empty_ptr_rd_ack,
   output logic [A_WIDTH-1:0] next_empty_ptr,
   output logic               next_empty_ptr_val,
   output logic [A_WIDTH:0]   empty_ptr_cnt
);
   localparam int N = 2**A_WIDTH;
   localparam logic [A_WIDTH:0] FULL = (A_WIDTH+1)'(N);
   typedef enum logic {INIT, READY} state_t;
   state_t state, state_nxt;
   logic [A_WIDTH-1:0] mem [N];
   logic [A_WIDTH-1:0] init_cnt, wr_ptr, rd_ptr, wr_data;
   logic [A_WIDTH:0] cnt;
   logic push, pop, wr_en;
   // state register
   always_ff @(posedge clk) state <= srst ? INIT : state_nxt;
   // the sweep ends on the cycle that writes the last address
   always_comb state_nxt = (state == INIT && init_cnt == A_WIDTH'(N-1)) ? READY : state;
   // outputs and push/pop qualification; a push at full is accepted only alongside a pop
   always_comb begin
      next_empty_ptr_val = state == READY && cnt != '0;
      pop = next_empty_ptr_rd_ack && next_empty_ptr_val;
      push = state == READY && add_empty_ptr_en && (cnt != FULL || pop);
      wr_en = state == INIT || push;
      wr_data = state == INIT ? init_cnt : add_empty_ptr;
      next_empty_ptr = next_empty_ptr_val ? mem[rd_ptr] : '0;
   end
   // pointers and occupancy; pointers wrap naturally at N
   always_ff @(posedge clk) begin
      if (srst) begin
         init_cnt <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt <= '0;
      end else begin
         if (state == INIT) init_cnt <= init_cnt + A_WIDTH'(1);
         if (wr_en) wr_ptr <= wr_ptr + A_WIDTH'(1);
         if (pop) rd_ptr <= rd_ptr + A_WIDTH'(1);
         cnt <= cnt + (A_WIDTH+1)'(wr_en) - (A_WIDTH+1)'(pop);
      end
   end
   // storage array, read asynchronously for show-ahead
   always_ff @(posedge clk) if (wr_en && !srst) mem[wr_ptr] <= wr_data;
   assign empty_ptr_cnt = cnt;
endmodule

// File: tb/tb_empty_ptr_storage.sv
// tb_empty_ptr_storage: directed scenarios plus random traffic against a queue model
module tb_empty_ptr_storage;
   localparam int AW = 3;
   localparam int N = 8;
   logic clk = 0;
   logic srst = 1;
   logic [AW-1:0] add_empty_ptr = '0;
   logic add_empty_ptr_en = 0;
   logic next_empty_ptr_rd_ack = 0;
   logic [AW-1:0] next_empty_ptr;
   logic next_empty_ptr_val;
   logic [AW:0] empty_ptr_cnt;
   int total = 0;
   int bad = 0;
   int q[$];
   bit ready = 0;
   int init_left = N;
   logic exp_val;
   logic [AW-1:0] exp_head;
   logic [AW:0] exp_cnt;

   empty_ptr_storage #(.A_WIDTH(AW)) dut (
      .clk(clk), .srst(srst), .add_empty_ptr(add_empty_ptr), .add_empty_ptr_en(add_empty_ptr_en),
      .next_empty_ptr_rd_ack(next_empty_ptr_rd_ack), .next_empty_ptr(next_empty_ptr),
      .next_empty_ptr_val(next_empty_ptr_val), .empty_ptr_cnt(empty_ptr_cnt));

   always #5 clk = ~clk;

   // one clock: drive inputs, advance the queue model at the edge, then sample-ready expectations
   task automatic step(input logic rst, input logic en, input int v, input logic ack);
      bit can_pop, can_push;
      srst = rst;
      add_empty_ptr_en = en;
      add_empty_ptr = AW'(v);
      next_empty_ptr_rd_ack = ack;
      @(posedge clk);
      if (rst) begin
         q.delete();
         ready = 0;
         init_left = N;
      end else if (!ready) begin
         q.push_back(N - init_left);
         init_left--;
         if (init_left == 0) ready = 1;
      end else begin
         can_pop = ack && q.size() > 0;
         can_push = en && (q.size() < N || can_pop);
         if (can_pop) void'(q.pop_front());
         if (can_push) q.push_back(v);
      end
      #1;
      exp_val = ready && q.size() > 0;
      exp_head = exp_val ? AW'(q[0]) : '0;
      exp_cnt = (AW+1)'(q.size());
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) step(1, 0, 0, 0);
      for (int i = 0; i < N; i++) step(0, 0, 0, 0);
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, 0);
         total++;
         if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {1'b0, 3'd0, 4'd0}) begin
            bad++;
            $display("FAIL reset: val=%0b head=%0d cnt=%0d want 0/0/0", next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt);
         end
      end
      for (int i = 0; i < N; i++) begin
         step(0, 0, 0, 0);
         total++;
         if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {exp_val, exp_head, exp_cnt}) begin
            bad++;
            $display("FAIL init[%0d]: val=%0b head=%0d cnt=%0d want %0b/%0d/%0d", i, next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt, exp_val, exp_head, exp_cnt);
         end
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {1'b1, 3'd0, 4'd8}) begin
            bad++;
            $display("FAIL init_done: val=%0b head=%0d cnt=%0d want 1/0/8", next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt);
         end
         step(0, 0, 0, 0);
      end
   endtask

   task automatic test_drain;
      for (int i = 0; i < N + 1; i++) begin
         total++;
         if (i < N && (next_empty_ptr_val !== 1'b1 || next_empty_ptr !== AW'(i))) begin
            bad++;
            $display("FAIL drain_head[%0d]: val=%0b head=%0d want 1/%0d", i, next_empty_ptr_val, next_empty_ptr, i);
         end
         step(0, 0, 0, 1);
         total++;
         if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {exp_val, exp_head, exp_cnt}) begin
            bad++;
            $display("FAIL drain[%0d]: val=%0b head=%0d cnt=%0d want %0b/%0d/%0d", i, next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt, exp_val, exp_head, exp_cnt);
         end
      end
   endtask

   task automatic test_refill;
      step(0, 1, 5, 0);
      total++;
      if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {1'b1, 3'd5, 4'd1}) begin
         bad++;
         $display("FAIL refill_first: val=%0b head=%0d cnt=%0d want 1/5/1", next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt);
      end
      step(0, 1, 2, 0);
      total++;
      if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {1'b1, 3'd5, 4'd2}) begin
         bad++;
         $display("FAIL refill_second: val=%0b head=%0d cnt=%0d want 1/5/2", next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt);
      end
      step(0, 0, 0, 1);
      total++;
      if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {1'b1, 3'd2, 4'd1}) begin
         bad++;
         $display("FAIL refill_pop: val=%0b head=%0d cnt=%0d want 1/2/1", next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt);
      end
      step(0, 0, 0, 1);
      total++;
      if ({next_empty_ptr_val, empty_ptr_cnt} !== {1'b0, 4'd0}) begin
         bad++;
         $display("FAIL refill_empty: val=%0b cnt=%0d want 0/0", next_empty_ptr_val, empty_ptr_cnt);
      end
   endtask

   task automatic test_simul_empty;
      step(0, 1, 6, 1);
      total++;
      if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {1'b1, 3'd6, 4'd1}) begin
         bad++;
         $display("FAIL simul_empty: val=%0b head=%0d cnt=%0d want 1/6/1", next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt);
      end
      step(0, 0, 0, 1);
   endtask

   // drains everything, comparing each head against an explicit expected list
   task automatic drain_expect(input string name, input int exp_list[$]);
      foreach (exp_list[i]) begin
         total++;
         if (next_empty_ptr_val !== 1'b1 || next_empty_ptr !== AW'(exp_list[i])) begin
            bad++;
            $display("FAIL %s[%0d]: val=%0b head=%0d want 1/%0d", name, i, next_empty_ptr_val, next_empty_ptr, exp_list[i]);
         end
         step(0, 0, 0, 1);
      end
      total++;
      if ({next_empty_ptr_val, empty_ptr_cnt} !== {1'b0, 4'd0}) begin
         bad++;
         $display("FAIL %s_end: val=%0b cnt=%0d want 0/0", name, next_empty_ptr_val, empty_ptr_cnt);
      end
   endtask

   task automatic test_simul_full;
      do_reset(1);
      step(0, 1, 3, 1);
      total++;
      if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {1'b1, 3'd1, 4'd8}) begin
         bad++;
         $display("FAIL simul_full: val=%0b head=%0d cnt=%0d want 1/1/8", next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt);
      end
      drain_expect("simul_full_order", '{1, 2, 3, 4, 5, 6, 7, 3});
   endtask

   task automatic test_overflow;
      do_reset(1);
      step(0, 1, 4, 0);
      total++;
      if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {1'b1, 3'd0, 4'd8}) begin
         bad++;
         $display("FAIL overflow: val=%0b head=%0d cnt=%0d want 1/0/8", next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt);
      end
      drain_expect("overflow_order", '{0, 1, 2, 3, 4, 5, 6, 7});
   endtask

   task automatic test_reset_mid;
      do_reset(1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
      total++;
      if (empty_ptr_cnt !== 4'd5) begin
         bad++;
         $display("FAIL mid_cnt: cnt=%0d want 5", empty_ptr_cnt);
      end
      step(0, 1, 1, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < N; i++) begin
         total++;
         if (next_empty_ptr_val !== 1'b0) begin
            bad++;
            $display("FAIL mid_init[%0d]: val=%0b want 0", i, next_empty_ptr_val);
         end
         step(0, 0, 0, 0);
      end
      total++;
      if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {1'b1, 3'd0, 4'd8}) begin
         bad++;
         $display("FAIL mid_ready: val=%0b head=%0d cnt=%0d want 1/0/8", next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt);
      end
      drain_expect("mid_order", '{0, 1, 2, 3, 4, 5, 6, 7});
   endtask

   task automatic test_random;
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, N - 1)), $urandom_range(0, 2) != 0);
         total++;
         if ({next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt} !== {exp_val, exp_head, exp_cnt}) begin
            bad++;
            $display("FAIL random[%0d]: val=%0b head=%0d cnt=%0d want %0b/%0d/%0d", i, next_empty_ptr_val, next_empty_ptr, empty_ptr_cnt, exp_val, exp_head, exp_cnt);
         end
      end
   endtask

   initial begin
      test_reset;
      test_drain;
      test_refill;
      test_simul_empty;
      test_simul_full;
      test_overflow;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/empty_ptr_storage.md
# empty_ptr_storage

Free-pointer storage for the hash table's data memory: the slave end of `empty_ptr_storage_if`. After reset it self-initialises to hold every table address `0..2**A_WIDTH-1` as free. It hands free pointers to the insert logic through a show-ahead read/ack port and takes back pointers freed by delete logic. Internally it is a circular FIFO of depth `2**A_WIDTH` with an init sweep state machine.

## Interface

Parameters:
- `A_WIDTH`, default `hash_table::TABLE_ADDR_WIDTH`: pointer width. `N = 2**A_WIDTH` entries.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `srst`, in, 1: reset, synchronous and active-high.
- `add_empty_ptr`, in, `A_WIDTH`: pointer being returned to storage.
- `add_empty_ptr_en`, in, 1: push strobe for `add_empty_ptr`.
- `next_empty_ptr_rd_ack`, in, 1: pop the current head pointer.
- `next_empty_ptr`, out, `A_WIDTH`: head free pointer (show-ahead).
- `next_empty_ptr_val`, out, 1: head pointer is valid. 0 means there are no free pointers or the block is initialising.
- `empty_ptr_cnt`, out, `A_WIDTH+1`: number of stored free pointers (status/verification).

## Operation

- **States:** `INIT`, `READY`.
- **srst=1 (any state, any time):**
  - Next state is `INIT`.
  - `init_cnt`, `wr_ptr`, `rd_ptr` = 0; count = 0.
  - Outputs: `next_empty_ptr_val`=0, `next_empty_ptr`=0, `empty_ptr_cnt`=0.
  - Pending adds and acks are discarded.
- **INIT:**
  - Each cycle, writes `init_cnt` at `wr_ptr`, then increments `wr_ptr`, `init_cnt` and count.
  - After the write of `N-1`, goes to `READY` with count=N and `wr_ptr` wrapped to 0.
  - `add_empty_ptr_en` and `next_empty_ptr_rd_ack` are ignored. Masters must not issue them in this state.
- **READY, push:**
  - When `add_empty_ptr_en`=1 and count<N: store at `wr_ptr`, increment `wr_ptr` modulo N.
  - When count==N and no pop occurs in the same cycle: the push is dropped (double-free). Count stays N and no state is corrupted.
- **READY, pop:**
  - When `next_empty_ptr_rd_ack`=1 and `next_empty_ptr_val`=1: increment `rd_ptr` modulo N.
  - An ack with val=0 is ignored.
- **Simultaneous push and pop:**
  - Both are performed and count is unchanged.
  - At count==N the push is accepted, because the pop frees a slot.
  - At count==0 only the push takes effect; the pop is ignored since val=0.
- **Count arithmetic:** `A_WIDTH+1` bits, range 0..N, never wraps.
- **Outputs:**
  - `next_empty_ptr_val` = (state==`READY`) && count!=0.
  - `next_empty_ptr` = mem[`rd_ptr`]. It is only meaningful when val=1.
- **Ordering:** strict FIFO. Initial order is ascending 0..N-1; returned pointers follow after the pointers already stored.
- **Storage:** N x `A_WIDTH` memory, either registers or RAM. Any RAM read latency is hidden so that show-ahead timing below holds.

## Timing

- **Init duration:** with srst low from edge e1, sweep writes occur at e1..eN. `next_empty_ptr_val`=1 and `next_empty_ptr`=0 are seen after eN.
- **Pop:** an ack sampled at edge t updates head to the next entry after t. Back-to-back acks every cycle are supported with no bubble while count>1.
- **Push into empty storage:** a push at edge t gives val=1 with head = pushed value after t (1-cycle latency).
- **Count:** `empty_ptr_cnt` updates on the same edge as the push/pop that changes it.
- **Reset mid-operation:** val drops to 0 one edge after srst is sampled, then the full N-cycle sweep repeats.

## Test plan

All scenarios use `A_WIDTH`=3, N=8.

- **Reset/init:** srst 2 cycles, then low. Val=0 for 8 cycles, then val=1, head=0, cnt=8; while held there, head stays 0.
- **Drain and empty:** 8 consecutive acks. Heads seen are 0,1,...,7; cnt goes 8 down to 0. After the 8th pop val=0; a 9th ack is ignored and cnt stays 0.
- **Refill and order:** from empty, push 5, then 2. Val=1 and head=5 one cycle after the first push; cnt=2. Acks return 5 then 2.
- **Simultaneous at boundaries:**
  - Full (cnt=8): push 3 + ack in the same cycle. Head advances, cnt=8, and 3 comes out after the seven remaining pointers.
  - Empty: push 6 + ack in the same cycle. cnt=1, head=6.
- **Overflow drop:** at cnt=8, push 4 with no ack. cnt stays 8, and draining returns exactly the original 8 entries.
- **Reset mid-operation:** pop 3 (cnt=5), push 1, then assert srst for 1 cycle. Val=0 through the 8-cycle init, then head=0 and cnt=8; the pushed 1 does not appear out of order.
